tri_raster: RTL and testbench

TRI_RASTER -- requirements
Module: tri_raster

---
 rtl/raster_pkg.sv | 27 ++
 rtl/tri_setup.sv | 167 ++++++++++++++++
 rtl/tri_raster.sv | 170 +++++++++++++++++
 tb/tb_tri_raster.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types and default geometry for the triangle rasteriser:
// FSM state encoding and the per-edge incremental coefficient bundle.
package raster_pkg;

    localparam int COORD_W_DEF  = 16;
    localparam int FRAC_W_DEF   = 4;
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // Edge accumulators hold a product of two signed coordinate differences
    // plus guard bits; sized for coordinates up to COORD_W_DEF wide.
    localparam int EDGE_W = 2*COORD_W_DEF + 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN,
        FINISH
    } state_t;

    typedef struct packed {
        logic signed [EDGE_W-1:0] e0;
        logic signed [EDGE_W-1:0] step_x;
        logic signed [EDGE_W-1:0] step_y;
    } edge_coef_t;

endpackage

// File: rtl/tri_setup.sv
// Two-cycle triangle setup: signed area and bbox in the first cycle, winding
// fix-up, edge coefficients at the bbox origin and clamping in the second.
module tri_setup
    import raster_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [COORD_W-1:0]            p1x,
    input  logic [COORD_W-1:0]            p1y,
    input  logic [COORD_W-1:0]            p2x,
    input  logic [COORD_W-1:0]            p2y,
    input  logic [COORD_W-1:0]            p3x,
    input  logic [COORD_W-1:0]            p3y,
    input  logic                          cull_en,
    output logic                          vld,
    output logic                          kill,
    output edge_coef_t                    coef_a,
    output edge_coef_t                    coef_b,
    output edge_coef_t                    coef_c,
    output logic [$clog2(SCREEN_W)-1:0]   bbox_x0,
    output logic [$clog2(SCREEN_W)-1:0]   bbox_x1,
    output logic [$clog2(SCREEN_H)-1:0]   bbox_y0,
    output logic [$clog2(SCREEN_H)-1:0]   bbox_y1
);

    localparam int XW     = $clog2(SCREEN_W);
    localparam int YW     = $clog2(SCREEN_H);
    localparam int IW     = COORD_W - FRAC_W;
    localparam int AREA_W = 2*COORD_W + 2;
    localparam logic [IW-1:0] XMAX_I = IW'(SCREEN_W - 1);
    localparam logic [IW-1:0] YMAX_I = IW'(SCREEN_H - 1);

    function automatic logic signed [AREA_W-1:0] widen_a(input logic [COORD_W-1:0] c);
        return $signed({{(AREA_W-COORD_W){1'b0}}, c});
    endfunction

    function automatic logic signed [EDGE_W-1:0] widen_e(input logic [COORD_W-1:0] c);
        return $signed({{(EDGE_W-COORD_W){1'b0}}, c});
    endfunction

    function automatic logic [IW-1:0] pix_idx(input logic [COORD_W-1:0] c);
        return c[COORD_W-1:FRAC_W];
    endfunction

    function automatic logic [IW-1:0] min3(input logic [IW-1:0] a, b, c);
        logic [IW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [IW-1:0] max3(input logic [IW-1:0] a, b, c);
        logic [IW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [XW-1:0] clamp_x(input logic [IW-1:0] i);
        return (i > XMAX_I) ? XW'(SCREEN_W - 1) : i[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [IW-1:0] i);
        return (i > YMAX_I) ? YW'(SCREEN_H - 1) : i[YW-1:0];
    endfunction

    // E(p) = (xj-xi)(py-yi) - (yj-yi)(px-xi), evaluated at the bbox origin,
    // with the per-pixel column and row increments.
    function automatic edge_coef_t edge_eq(
        input logic [COORD_W-1:0]       xi, yi, xj, yj,
        input logic signed [EDGE_W-1:0] sx, sy
    );
        logic signed [EDGE_W-1:0] ex;
        logic signed [EDGE_W-1:0] ey;
        edge_coef_t               r;
        ex       = widen_e(xj) - widen_e(xi);
        ey       = widen_e(yj) - widen_e(yi);
        r.e0     = ex * (sy - widen_e(yi)) - ey * (sx - widen_e(xi));
        r.step_x = -(ey <<< FRAC_W);
        r.step_y = ex <<< FRAC_W;
        return r;
    endfunction

    // Stage p0: vertex capture
    logic [COORD_W-1:0] x1_p0, y1_p0, x2_p0, y2_p0, x3_p0, y3_p0;
    logic               cull_p0;
    logic               vld_p0;

    always_ff @(posedge clk) begin
        if (load) begin
            x1_p0   <= p1x;
            y1_p0   <= p1y;
            x2_p0   <= p2x;
            y2_p0   <= p2y;
            x3_p0   <= p3x;
            y3_p0   <= p3y;
            cull_p0 <= cull_en;
        end
    end

    // Stage p1: signed area and raw pixel-index bbox
    logic signed [AREA_W-1:0] area_c;
    logic signed [AREA_W-1:0] area_p1;
    logic [COORD_W-1:0]       x1_p1, y1_p1, x2_p1, y2_p1, x3_p1, y3_p1;
    logic [IW-1:0]            xlo_p1, xhi_p1, ylo_p1, yhi_p1;
    logic                     cull_p1;
    logic                     vld_p1;

    assign area_c = (widen_a(x2_p0) - widen_a(x1_p0)) * (widen_a(y3_p0) - widen_a(y1_p0))
                  - (widen_a(x3_p0) - widen_a(x1_p0)) * (widen_a(y2_p0) - widen_a(y1_p0));

    always_ff @(posedge clk) begin
        area_p1 <= area_c;
        x1_p1   <= x1_p0;
        y1_p1   <= y1_p0;
        x2_p1   <= x2_p0;
        y2_p1   <= y2_p0;
        x3_p1   <= x3_p0;
        y3_p1   <= y3_p0;
        cull_p1 <= cull_p0;
        xlo_p1  <= min3(pix_idx(x1_p0), pix_idx(x2_p0), pix_idx(x3_p0));
        xhi_p1  <= max3(pix_idx(x1_p0), pix_idx(x2_p0), pix_idx(x3_p0));
        ylo_p1  <= min3(pix_idx(y1_p0), pix_idx(y2_p0), pix_idx(y3_p0));
        yhi_p1  <= max3(pix_idx(y1_p0), pix_idx(y2_p0), pix_idx(y3_p0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= load;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p2: winding fix-up, edge coefficients, clamp (consumed by the FSM)
    logic                     neg_p2;
    logic [COORD_W-1:0]       bx_p2, by_p2, cx_p2, cy_p2;
    logic signed [EDGE_W-1:0] sx_p2, sy_p2;

    always_comb begin
        neg_p2 = area_p1[AREA_W-1];
        bx_p2  = neg_p2 ? x3_p1 : x2_p1;
        by_p2  = neg_p2 ? y3_p1 : y2_p1;
        cx_p2  = neg_p2 ? x2_p1 : x3_p1;
        cy_p2  = neg_p2 ? y2_p1 : y3_p1;
        sx_p2  = EDGE_W'(clamp_x(xlo_p1)) << FRAC_W;
        sy_p2  = EDGE_W'(clamp_y(ylo_p1)) << FRAC_W;
    end

    assign vld     = vld_p1;
    assign kill    = (area_p1 == '0) || (neg_p2 && cull_p1)
                  || (xlo_p1 > XMAX_I) || (ylo_p1 > YMAX_I);
    assign coef_a  = edge_eq(x1_p1, y1_p1, bx_p2, by_p2, sx_p2, sy_p2);
    assign coef_b  = edge_eq(bx_p2, by_p2, cx_p2, cy_p2, sx_p2, sy_p2);
    assign coef_c  = edge_eq(cx_p2, cy_p2, x1_p1, y1_p1, sx_p2, sy_p2);
    assign bbox_x0 = clamp_x(xlo_p1);
    assign bbox_x1 = clamp_x(xhi_p1);
    assign bbox_y0 = clamp_y(ylo_p1);
    assign bbox_y1 = clamp_y(yhi_p1);

endmodule

// File: rtl/tri_raster.sv
// Triangle rasteriser: scans the clamped bbox row-major, one sample per cycle,
// emitting covered pixels over a valid/ready handshake.
module tri_raster
    import raster_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [COORD_W-1:0]                       p1x,
    input  logic [COORD_W-1:0]                       p1y,
    input  logic [COORD_W-1:0]                       p2x,
    input  logic [COORD_W-1:0]                       p2y,
    input  logic [COORD_W-1:0]                       p3x,
    input  logic [COORD_W-1:0]                       p3y,
    input  logic                                     cull_en,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     pix_valid,
    input  logic                                     pix_ready,
    output logic [$clog2(SCREEN_W)-1:0]              pix_x,
    output logic [$clog2(SCREEN_H)-1:0]              pix_y,
    output logic [$clog2(SCREEN_W*SCREEN_H+1)-1:0]   pix_count
);

    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);

    state_t                   state;
    logic                     accept, setup_vld, setup_kill, scan_load;
    logic                     out_free, scan_adv, row_end, last_sample, covered, scan_end;
    edge_coef_t               coef [3];
    logic [XW-1:0]            bb_x0, bb_x1, cx, x_lo, x_hi;
    logic [YW-1:0]            bb_y0, bb_y1, cy, y_hi;
    logic signed [EDGE_W-1:0] e_cur [3];
    logic signed [EDGE_W-1:0] e_row [3];
    logic signed [EDGE_W-1:0] stp_x [3];
    logic signed [EDGE_W-1:0] stp_y [3];

    tri_setup #(
        .COORD_W  (COORD_W),
        .FRAC_W   (FRAC_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_setup (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .p1x      (p1x),
        .p1y      (p1y),
        .p2x      (p2x),
        .p2y      (p2y),
        .p3x      (p3x),
        .p3y      (p3y),
        .cull_en  (cull_en),
        .vld      (setup_vld),
        .kill     (setup_kill),
        .coef_a   (coef[0]),
        .coef_b   (coef[1]),
        .coef_c   (coef[2]),
        .bbox_x0  (bb_x0),
        .bbox_x1  (bb_x1),
        .bbox_y0  (bb_y0),
        .bbox_y1  (bb_y1)
    );

    assign accept      = (state == IDLE) && start;
    assign scan_load   = (state == SETUP) && setup_vld && !setup_kill;
    assign out_free    = !pix_valid || pix_ready;
    assign scan_adv    = (state == SCAN) && out_free && !scan_end;
    assign row_end     = (cx == x_hi);
    assign last_sample = row_end && (cy == y_hi);
    assign covered     = !e_cur[0][EDGE_W-1] && !e_cur[1][EDGE_W-1] && !e_cur[2][EDGE_W-1];

    // Scan position and incremental edge values; frozen while the output is stalled
    always_ff @(posedge clk) begin
        if (scan_load) begin
            cx   <= bb_x0;
            cy   <= bb_y0;
            x_lo <= bb_x0;
            x_hi <= bb_x1;
            y_hi <= bb_y1;
            for (int i = 0; i < 3; i++) begin
                e_cur[i] <= coef[i].e0;
                e_row[i] <= coef[i].e0;
                stp_x[i] <= coef[i].step_x;
                stp_y[i] <= coef[i].step_y;
            end
        end else if (scan_adv && !last_sample) begin
            if (row_end) begin
                cx <= x_lo;
                cy <= cy + 1'b1;
                for (int i = 0; i < 3; i++) begin
                    e_row[i] <= e_row[i] + stp_y[i];
                    e_cur[i] <= e_row[i] + stp_y[i];
                end
            end else begin
                cx <= cx + 1'b1;
                for (int i = 0; i < 3; i++) begin
                    e_cur[i] <= e_cur[i] + stp_x[i];
                end
            end
        end
    end

    // Control FSM with registered handshake/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_count <= '0;
            scan_end  <= 1'b0;
        end else begin
            if (accept)
                pix_count <= '0;
            else if (pix_valid && pix_ready)
                pix_count <= pix_count + 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SETUP;
                        busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (setup_vld) begin
                        if (setup_kill) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state    <= SCAN;
                            scan_end <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (out_free) begin
                        // Last sample has already been presented and accepted
                        if (scan_end) begin
                            pix_valid <= 1'b0;
                            state     <= FINISH;
                            done      <= 1'b1;
                        end else begin
                            pix_valid <= covered;
                            pix_x     <= cx;
                            pix_y     <= cy;
                            scan_end  <= last_sample;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_raster.sv
// Bench for tri_raster: directed cases plus randomized triangles, checked
// against a direct-evaluation coverage model.
module tb_tri_raster;

    localparam int COORD_W  = 16;
    localparam int FRAC_W   = 4;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int XW       = $clog2(SCREEN_W);
    localparam int YW       = $clog2(SCREEN_H);
    localparam int CW       = $clog2(SCREEN_W*SCREEN_H+1);
    localparam int LIMIT    = 3000;

    logic               clk = 1'b0;
    logic               reset, start, cull_en, pix_ready;
    logic [COORD_W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
    logic               busy, done, pix_valid;
    logic [XW-1:0]      pix_x;
    logic [YW-1:0]      pix_y;
    logic [CW-1:0]      pix_count;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int xbase[4] = '{0, 300, 620, 700};
    int ybase[3] = '{0, 200, 460};

    always #5 clk = ~clk;

    tri_raster #(
        .COORD_W  (COORD_W),
        .FRAC_W   (FRAC_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .p1x       (p1x),
        .p1y       (p1y),
        .p2x       (p2x),
        .p2y       (p2y),
        .p3x       (p3x),
        .p3y       (p3y),
        .cull_en   (cull_en),
        .busy      (busy),
        .done      (done),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_count (pix_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Coverage by direct evaluation of the three edge functions at every bbox sample.
    task automatic model(input int x1, y1, x2, y2, x3, y3, input bit cull);
        longint a, e1, e2, e3, sx, sy;
        int t, xmin, xmax, ymin, ymax;
        exp_q.delete();
        a = longint'(x2 - x1) * longint'(y3 - y1) - longint'(x3 - x1) * longint'(y2 - y1);
        if (a == 0 || (a < 0 && cull)) return;
        if (a < 0) begin
            t = x2; x2 = x3; x3 = t;
            t = y2; y2 = y3; y3 = t;
        end
        xmin = x1 >> FRAC_W; xmax = xmin;
        ymin = y1 >> FRAC_W; ymax = ymin;
        foreach (xbase[k]) ; // keep arrays referenced simply
        if ((x2 >> FRAC_W) < xmin) xmin = x2 >> FRAC_W;
        if ((x3 >> FRAC_W) < xmin) xmin = x3 >> FRAC_W;
        if ((x2 >> FRAC_W) > xmax) xmax = x2 >> FRAC_W;
        if ((x3 >> FRAC_W) > xmax) xmax = x3 >> FRAC_W;
        if ((y2 >> FRAC_W) < ymin) ymin = y2 >> FRAC_W;
        if ((y3 >> FRAC_W) < ymin) ymin = y3 >> FRAC_W;
        if ((y2 >> FRAC_W) > ymax) ymax = y2 >> FRAC_W;
        if ((y3 >> FRAC_W) > ymax) ymax = y3 >> FRAC_W;
        if (xmin > SCREEN_W - 1 || ymin > SCREEN_H - 1) return;
        if (xmax > SCREEN_W - 1) xmax = SCREEN_W - 1;
        if (ymax > SCREEN_H - 1) ymax = SCREEN_H - 1;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                sx = longint'(x) * 16;
                sy = longint'(y) * 16;
                e1 = longint'(x2 - x1) * (sy - y1) - longint'(y2 - y1) * (sx - x1);
                e2 = longint'(x3 - x2) * (sy - y2) - longint'(y3 - y2) * (sx - x2);
                e3 = longint'(x1 - x3) * (sy - y3) - longint'(y1 - y3) * (sx - x3);
                if (e1 >= 0 && e2 >= 0 && e3 >= 0) exp_q.push_back(x * 1024 + y);
            end
        end
    endtask

    // mode 0: always ready; 1: random ready; 2: 3-cycle stall on the 2nd pixel.
    // exp_lat < 0 skips the done-latency check (latency counted from the start cycle).
    task automatic run_tri(input string name, input int x1, y1, x2, y2, x3, y3,
                           input bit cull, input int mode, input int exp_lat);
        int  nexp, hs, stall, lat, prev_code, code;
        bit  prev_hold, seen_done;
        model(x1, y1, x2, y2, x3, y3, cull);
        nexp = exp_q.size();
        hs = 0; stall = 0; prev_hold = 0; seen_done = 0; prev_code = 0;
        @(negedge clk);
        p1x = x1[15:0]; p1y = y1[15:0];
        p2x = x2[15:0]; p2y = y2[15:0];
        p3x = x3[15:0]; p3y = y3[15:0];
        cull_en = cull; start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        // a second start with different vertices while busy must be ignored
        p1x = 16'($urandom); p1y = 16'($urandom); p2x = 16'($urandom);
        p2y = 16'($urandom); p3x = 16'($urandom); p3y = 16'($urandom);
        cull_en = ~cull;
        chk({name, ":busy"}, busy, 1);
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            lat++;
            if (mode == 2 && pix_valid && hs == 1 && stall < 3) begin
                pix_ready = 1'b0;
                stall++;
                chk({name, ":stall_x"}, pix_x, 1);
                chk({name, ":stall_y"}, pix_y, 0);
            end else if (mode == 1) begin
                pix_ready = ($urandom_range(0, 3) != 0);
            end else begin
                pix_ready = 1'b1;
            end
            code = int'(pix_x) * 1024 + int'(pix_y);
            if (prev_hold) begin
                chk({name, ":hold_valid"}, pix_valid, 1);
                chk({name, ":hold_xy"}, code, prev_code);
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) chk({name, ":extra_pixel"}, code, -1);
                else chk({name, ":pixel"}, code, exp_q.pop_front());
                hs++;
            end
            prev_hold = pix_valid && !pix_ready;
            prev_code = code;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        chk({name, ":done_seen"}, seen_done, 1);
        chk({name, ":pixels_left"}, exp_q.size(), 0);
        chk({name, ":count"}, pix_count, nexp);
        if (exp_lat >= 0) chk({name, ":done_lat"}, lat, exp_lat);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk({name, ":no_2nd_done"}, done, 0);
            chk({name, ":no_valid_after"}, pix_valid, 0);
        end
        chk({name, ":busy_after"}, busy, 0);
        chk({name, ":count_hold"}, pix_count, nexp);
    endtask

    initial begin
        int x1, y1, x2, y2, x3, y3, bx, by;
        bit saw;
        reset = 1'b1; start = 1'b0; cull_en = 1'b0; pix_ready = 1'b1;
        p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:valid", pix_valid, 0);
        chk("rst:xy", {pix_x, pix_y}, 0);
        chk("rst:count", pix_count, 0);
        reset = 1'b0;
        @(negedge clk);

        run_tri("basic", 0, 0, 64, 0, 0, 64, 1'b0, 0, -1);
        run_tri("cull", 0, 0, 0, 64, 64, 0, 1'b1, 0, 3);
        run_tri("swap", 0, 0, 0, 64, 64, 0, 1'b0, 0, -1);
        run_tri("collinear", 0, 0, 32, 32, 64, 64, 1'b0, 0, 3);
        run_tri("stall", 0, 0, 64, 0, 0, 64, 1'b0, 2, -1);
        run_tri("right_edge", 636*16, 0, 700*16, 0, 636*16, 64, 1'b0, 1, -1);
        run_tri("offscreen", 650*16, 10, 660*16, 10, 650*16, 100, 1'b0, 0, 3);

        // reset in the middle of a scan
        @(negedge clk);
        p1x = 16'(636*16); p1y = 16'd0; p2x = 16'(700*16); p2y = 16'd0;
        p3x = 16'(636*16); p3y = 16'd64; cull_en = 1'b0; start = 1'b1; pix_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 20 && !saw; c++) begin
            @(negedge clk);
            saw = pix_valid;
        end
        chk("midrst:saw_valid", saw, 1);
        reset = 1'b1;
        #1;
        chk("midrst:valid", pix_valid, 0);
        chk("midrst:busy", busy, 0);
        chk("midrst:xy", {pix_x, pix_y}, 0);
        chk("midrst:count", pix_count, 0);
        @(negedge clk);
        reset = 1'b0; pix_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("midrst:no_done", done, 0);
            chk("midrst:no_valid", pix_valid, 0);
        end

        for (int t = 0; t < 16; t++) begin
            bx = xbase[$urandom_range(0, 3)] * 16;
            by = ybase[$urandom_range(0, 2)] * 16;
            x1 = bx + int'($urandom_range(0, 24*16-1)); y1 = by + int'($urandom_range(0, 24*16-1));
            x2 = bx + int'($urandom_range(0, 24*16-1)); y2 = by + int'($urandom_range(0, 24*16-1));
            x3 = bx + int'($urandom_range(0, 24*16-1)); y3 = by + int'($urandom_range(0, 24*16-1));
            run_tri("rand", x1, y1, x2, y2, x3, y3, 1'($urandom_range(0, 1)), 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
